// File: rtl/reg_bank_32_pkg.sv
// Shared constants for the integer register bank: well-known register indices
// and the ABI reset values for sp/gp, used by both the RTL and the bench.
package reg_bank_32_pkg;

  localparam int          NUM_REGS        = 32;
  localparam int          ADDR_WIDTH      = 5;
  localparam logic [4:0]  REG_ZERO        = 5'd0;
  localparam logic [4:0]  REG_SP          = 5'd2;
  localparam logic [4:0]  REG_GP          = 5'd3;
  localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_INIT_DEFAULT = 32'h1000_8000;

endpackage

// File: rtl/reg_bank_32_decoder_5to32.sv
// One-hot decoder: bit n of onehot is set when en is high and addr == n.
module decoder_5to32
  import reg_bank_32_pkg::*;
(
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_REGS-1:0]   onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign onehot[gi] = en && (addr == ADDR_WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/reg_bank_32.sv
// Architectural register file x0..x31 with one write port, all registers exposed
// in parallel, and a per-register pending scoreboard for multicycle-load stalls.
module reg_bank_32
  import reg_bank_32_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = DATA_WIDTH'(SP_INIT_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] GP_INIT    = DATA_WIDTH'(GP_INIT_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [4:0]            rsv_addr,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic [DATA_WIDTH-1:0] Q0,  Q1,  Q2,  Q3,  Q4,  Q5,  Q6,  Q7,
  output logic [DATA_WIDTH-1:0] Q8,  Q9,  Q10, Q11, Q12, Q13, Q14, Q15,
  output logic [DATA_WIDTH-1:0] Q16, Q17, Q18, Q19, Q20, Q21, Q22, Q23,
  output logic [DATA_WIDTH-1:0] Q24, Q25, Q26, Q27, Q28, Q29, Q30, Q31,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  stall
);

  logic [NUM_REGS-1:0]   wr_hot;
  logic [NUM_REGS-1:0]   rsv_hot;
  logic [DATA_WIDTH-1:0] regs_view [NUM_REGS];
  logic                  unused_hot_bits;

  decoder_5to32 u_wr_dec  (.en(wr_en),  .addr(wr_addr),  .onehot(wr_hot));
  decoder_5to32 u_rsv_dec (.en(rsv_en), .addr(rsv_addr), .onehot(rsv_hot));

  // x0 has no storage, so its decode lines go nowhere.
  assign unused_hot_bits = wr_hot[0] ^ rsv_hot[0];
  assign regs_view[0]    = '0;
  assign pending[0]      = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [DATA_WIDTH-1:0] RST_VAL =
        (gi == int'(REG_SP)) ? SP_INIT :
        (gi == int'(REG_GP)) ? GP_INIT : '0;

      logic [DATA_WIDTH-1:0] data_q;
      logic                  pend_q;
      logic                  pend_d;

      // A reservation on the same edge as the write-back wins: a newer load owns the register.
      assign pend_d = rsv_hot[gi] | (pend_q & ~wr_hot[gi]);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_q <= RST_VAL;
          pend_q <= 1'b0;
        end else begin
          if (wr_hot[gi]) data_q <= wr_data;
          pend_q <= pend_d;
        end
      end

      assign regs_view[gi] = data_q;
      assign pending[gi]   = pend_q;
    end
  endgenerate

  assign stall = ((rs1_addr != REG_ZERO) && pending[rs1_addr]) ||
                 ((rs2_addr != REG_ZERO) && pending[rs2_addr]);

  assign Q0  = regs_view[0];
  assign Q1  = regs_view[1];
  assign Q2  = regs_view[2];
  assign Q3  = regs_view[3];
  assign Q4  = regs_view[4];
  assign Q5  = regs_view[5];
  assign Q6  = regs_view[6];
  assign Q7  = regs_view[7];
  assign Q8  = regs_view[8];
  assign Q9  = regs_view[9];
  assign Q10 = regs_view[10];
  assign Q11 = regs_view[11];
  assign Q12 = regs_view[12];
  assign Q13 = regs_view[13];
  assign Q14 = regs_view[14];
  assign Q15 = regs_view[15];
  assign Q16 = regs_view[16];
  assign Q17 = regs_view[17];
  assign Q18 = regs_view[18];
  assign Q19 = regs_view[19];
  assign Q20 = regs_view[20];
  assign Q21 = regs_view[21];
  assign Q22 = regs_view[22];
  assign Q23 = regs_view[23];
  assign Q24 = regs_view[24];
  assign Q25 = regs_view[25];
  assign Q26 = regs_view[26];
  assign Q27 = regs_view[27];
  assign Q28 = regs_view[28];
  assign Q29 = regs_view[29];
  assign Q30 = regs_view[30];
  assign Q31 = regs_view[31];

endmodule

// File: tb/tb_reg_bank_32.sv
// Directed plus randomized bench for reg_bank_32 against an array-based model
// of the register values and pending flags.
module tb_reg_bank_32;
  import reg_bank_32_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] q_w [32];
  logic [31:0] pending;
  logic        stall;

  logic [31:0] m_regs [32];
  bit          m_pend [32];
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  reg_bank_32 dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .Q0(q_w[0]),   .Q1(q_w[1]),   .Q2(q_w[2]),   .Q3(q_w[3]),
    .Q4(q_w[4]),   .Q5(q_w[5]),   .Q6(q_w[6]),   .Q7(q_w[7]),
    .Q8(q_w[8]),   .Q9(q_w[9]),   .Q10(q_w[10]), .Q11(q_w[11]),
    .Q12(q_w[12]), .Q13(q_w[13]), .Q14(q_w[14]), .Q15(q_w[15]),
    .Q16(q_w[16]), .Q17(q_w[17]), .Q18(q_w[18]), .Q19(q_w[19]),
    .Q20(q_w[20]), .Q21(q_w[21]), .Q22(q_w[22]), .Q23(q_w[23]),
    .Q24(q_w[24]), .Q25(q_w[25]), .Q26(q_w[26]), .Q27(q_w[27]),
    .Q28(q_w[28]), .Q29(q_w[29]), .Q30(q_w[30]), .Q31(q_w[31]),
    .pending(pending), .stall(stall)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
    m_regs[2] = 32'h7FFF_EFFC;
    m_regs[3] = 32'h1000_8000;
  endtask

  function automatic logic [31:0] model_pending_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic model_stall();
    return (rs1_addr != 0 && m_pend[rs1_addr]) || (rs2_addr != 0 && m_pend[rs2_addr]);
  endfunction

  task automatic check_stall(input string tag);
    logic exp_s;
    exp_s = model_stall();
    compared++;
    assert (stall === exp_s) else begin
      mismatched++;
      $error("FAIL %s stall: got %b expected %b", tag, stall, exp_s);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_p;
    for (int i = 0; i < 32; i++) begin
      compared++;
      assert (q_w[i] === m_regs[i]) else begin
        mismatched++;
        $error("FAIL %s Q%0d: got %h expected %h", tag, i, q_w[i], m_regs[i]);
      end
    end
    exp_p = model_pending_vec();
    compared++;
    assert (pending === exp_p) else begin
      mismatched++;
      $error("FAIL %s pending: got %h expected %h", tag, pending, exp_p);
    end
    check_stall(tag);
  endtask

  // One transaction: present inputs, check pre-edge stall, clock, update model, check state.
  task automatic tick(input string tag, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input bit re, input logic [4:0] ra, input logic [4:0] r1, input logic [4:0] r2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra; rs1_addr = r1; rs2_addr = r2;
    #1;
    check_stall({tag, "_pre"});
    @(posedge clk);
    if (we && wa != 0) begin
      m_regs[wa] = wd;
      m_pend[wa] = 1'b0;
    end
    if (re && ra != 0) m_pend[ra] = 1'b1;
    #1;
    check_all(tag);
    $display("%s: we=%0b wa=%0d wd=%h re=%0b ra=%0d rs1=%0d rs2=%0d -> pend=%h stall=%0b",
             tag, we, wa, wd, re, ra, r1, r2, pending, stall);
  endtask

  initial begin
    // Reset asserted mid-cycle must act immediately.
    #3 reset = 1'b0;
    model_reset();
    #1 check_all("reset_async");
    $display("reset_async: pend=%h Q2=%h Q3=%h", pending, q_w[2], q_w[3]);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    tick("basic_write", 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 5'd0, 5'd0);
    tick("x0_guard",    1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 5'd0, 5'd0);
    tick("rsv7",        0, 5'd0, 32'h0,         1, 5'd7, 5'd0, 5'd0);
    tick("stall7",      0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd0);
    tick("wb7",         1, 5'd7, 32'h1234,      0, 5'd0, 5'd7, 5'd0);
    tick("post_wb7",    0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd7);
    tick("conflict9",   1, 5'd9, 32'hA5A5,      1, 5'd9, 5'd0, 5'd9);
    tick("rsv10_wb9",   1, 5'd9, 32'h5A5A,      1, 5'd10, 5'd9, 5'd10);
    tick("re_rsv10",    0, 5'd0, 32'h0,         1, 5'd10, 5'd0, 5'd10);

    // Reset mid-operation discards a write presented in the same cycle.
    tick("setup_w4",    1, 5'd4, 32'h55,        0, 5'd0, 5'd0, 5'd0);
    tick("setup_r4",    0, 5'd0, 32'h0,         1, 5'd4, 5'd4, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hCAFE_F00D;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("reset_midop");
    @(posedge clk);
    #1 check_all("reset_hold");
    $display("reset_midop: pend=%h Q4=%h", pending, q_w[4]);
    wr_en = 1'b0; rsv_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 300; n++) begin
      tick($sformatf("rand%0d", n),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 15)),
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
